// File: rtl/fir_coeff_bank.sv
// Double-buffered KSIZE x KSIZE coefficient bank with MicroBlaze register access.
// The shadow bank is copied to the active bank on the first frame_start after a commit request.
module fir_coeff_bank #(
  parameter int unsigned KSIZE   = 5,
  parameter int unsigned COEFF_W = 16
) (
  input  logic                             microblaze_clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [7:0]                       wr_addr,
  input  logic [31:0]                      wr_data,
  input  logic [3:0]                       wr_strb,
  input  logic                             rd_en,
  input  logic [7:0]                       rd_addr,
  output logic [31:0]                      rd_data,
  input  logic                             frame_start,
  output logic [KSIZE*KSIZE*COEFF_W-1:0]   coeff_flat,
  output logic                             coeff_valid,
  output logic                             commit_done
);

  localparam int unsigned NCOEFF = KSIZE * KSIZE;
  localparam logic [7:0] A_CTRL   = 8'hF0;
  localparam logic [7:0] A_STATUS = 8'hF4;
  localparam logic [7:0] A_STREAM = 8'hF8;

  typedef enum logic {ST_IDLE, ST_PENDING} state_e;

  state_e             state_q, state_d;
  logic [COEFF_W-1:0] shadow_q [NCOEFF];
  logic [COEFF_W-1:0] shadow_d [NCOEFF];
  logic [COEFF_W-1:0] active_q [NCOEFF];
  logic [COEFF_W-1:0] active_d [NCOEFF];
  logic [5:0]         ptr_q, ptr_d;
  logic               loaded_q, loaded_d;
  logic               rd_sel_q, rd_sel_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [31:0]        rd_data_q, rd_data_d;

  logic wr_coeff, wr_ctrl, wr_stream, rd_coeff;
  logic commit_req, transfer, pending;

  assign wr_coeff   = wr_en && (32'(wr_addr) < 4 * NCOEFF);
  assign wr_ctrl    = wr_en && (wr_addr == A_CTRL);
  assign wr_stream  = wr_en && (wr_addr == A_STREAM);
  assign rd_coeff   = 32'(rd_addr) < 4 * NCOEFF;
  assign commit_req = wr_ctrl && wr_data[0];
  assign pending    = (state_q == ST_PENDING);

  // Lanes at or above COEFF_W fall off in the final truncation.
  function automatic logic [COEFF_W-1:0] merge_lanes(input logic [COEFF_W-1:0] old,
                                                     input logic [31:0] data,
                                                     input logic [3:0] strb);
    logic [31:0] w;
    w = 32'(old);
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
    end
    return w[COEFF_W-1:0];
  endfunction

  function automatic logic [31:0] sext(input logic [COEFF_W-1:0] v);
    logic signed [COEFF_W-1:0] s;
    s = v;
    return 32'(s);
  endfunction

  always_comb begin
    state_d  = state_q;
    transfer = 1'b0;
    case (state_q)
      ST_IDLE:    if (commit_req) state_d = ST_PENDING;
      ST_PENDING: if (frame_start) begin
                    state_d  = ST_IDLE;
                    transfer = 1'b1;
                  end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Transfer is applied first so a same-cycle shadow write only reaches the shadow bank.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    ptr_d    = ptr_q;
    loaded_d = loaded_q;
    rd_sel_d = rd_sel_q;
    valid_d  = valid_q;
    done_d   = transfer;
    if (transfer) begin
      active_d = shadow_q;
      valid_d  = 1'b1;
      loaded_d = 1'b0;
    end
    if (wr_coeff) begin
      for (int unsigned k = 0; k < NCOEFF; k++) begin
        if (32'(wr_addr[7:2]) == k) shadow_d[k] = merge_lanes(shadow_q[k], wr_data, wr_strb);
      end
    end
    if (wr_stream) begin
      for (int unsigned k = 0; k < NCOEFF; k++) begin
        if (32'(ptr_q) == k) shadow_d[k] = wr_data[COEFF_W-1:0];
      end
      if (32'(ptr_q) >= NCOEFF - 1) begin
        ptr_d    = '0;
        loaded_d = 1'b1;
      end else begin
        ptr_d = ptr_q + 6'd1;
      end
    end
    if (wr_ctrl) begin
      rd_sel_d = wr_data[3];
      if (wr_data[1]) begin
        ptr_d    = '0;
        loaded_d = 1'b0;
      end
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = '0;
      if (rd_coeff) begin
        for (int unsigned k = 0; k < NCOEFF; k++) begin
          if (32'(rd_addr[7:2]) == k) rd_data_d = rd_sel_q ? sext(active_q[k]) : sext(shadow_q[k]);
        end
      end else if (rd_addr == A_CTRL) begin
        rd_data_d = {28'b0, rd_sel_q, 3'b0};
      end else if (rd_addr == A_STATUS) begin
        rd_data_d = {16'b0, 2'b0, ptr_q, 5'b0, loaded_q, valid_q, pending};
      end
    end
  end

  always_ff @(posedge microblaze_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      loaded_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
      for (int unsigned k = 0; k < NCOEFF; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      loaded_q  <= loaded_d;
      rd_sel_q  <= rd_sel_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
    end
  end

  always_comb begin
    coeff_flat = '0;
    for (int unsigned k = 0; k < NCOEFF; k++) begin
      coeff_flat[k*COEFF_W +: COEFF_W] = active_q[k];
    end
  end

  assign rd_data     = rd_data_q;
  assign coeff_valid = valid_q;
  assign commit_done = done_q;

endmodule

// File: tb/tb_fir_coeff_bank.sv
// Scoreboard bench for fir_coeff_bank: directed scenarios followed by randomized traffic.
module tb_fir_coeff_bank;

  localparam int KS = 5;
  localparam int CW = 16;
  localparam int NC = KS * KS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_addr = '0;
  logic [31:0]       wr_data = '0;
  logic [3:0]        wr_strb = '0;
  logic              rd_en = 1'b0;
  logic [7:0]        rd_addr = '0;
  logic [31:0]       rd_data;
  logic              frame_start = 1'b0;
  logic [NC*CW-1:0]  coeff_flat;
  logic              coeff_valid;
  logic              commit_done;

  fir_coeff_bank #(.KSIZE(KS), .COEFF_W(CW)) dut (
    .microblaze_clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_start(frame_start), .coeff_flat(coeff_flat),
    .coeff_valid(coeff_valid), .commit_done(commit_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [CW-1:0] sh_m [NC];
  logic [CW-1:0] ac_m [NC];
  int            ptr_m;
  bit            loaded_m, pend_m, valid_m, rdsel_m;
  logic [31:0]   exp_q [$];
  logic [31:0]   last_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NC*CW-1:0] model_flat();
    logic [NC*CW-1:0] f;
    for (int k = 0; k < NC; k++) f[k*CW +: CW] = ac_m[k];
    return f;
  endfunction

  task automatic check_flat(input string name);
    logic [NC*CW-1:0] e;
    e = model_flat();
    n_checks++;
    if (coeff_flat !== e) begin
      n_fail++;
      $display("FAIL %s: coeff_flat got %h expected %h", name, coeff_flat, e);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      sh_m[k] = '0;
      ac_m[k] = '0;
    end
    ptr_m = 0; loaded_m = 0; pend_m = 0; valid_m = 0; rdsel_m = 0;
  endtask

  function automatic logic [31:0] exp_read(input logic [7:0] a);
    logic [CW-1:0] v;
    if (int'(a) < 4 * NC) begin
      v = rdsel_m ? ac_m[a / 4] : sh_m[a / 4];
      return {{(32-CW){v[CW-1]}}, v};
    end
    if (a == 8'hF0) return {28'b0, rdsel_m, 3'b0};
    if (a == 8'hF4) return {16'b0, 2'b0, 6'(ptr_m), 5'b0, loaded_m, valid_m, pend_m};
    return 32'h0;
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit was_pending);
    logic [31:0] mask, merged;
    if (int'(a) < 4 * NC) begin
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      merged = (32'(sh_m[a / 4]) & ~mask) | (d & mask);
      sh_m[a / 4] = merged[CW-1:0];
    end else if (a == 8'hF0) begin
      if (d[0] && !was_pending) pend_m = 1;
      if (d[1]) begin ptr_m = 0; loaded_m = 0; end
      rdsel_m = d[3];
    end else if (a == 8'hF8) begin
      sh_m[ptr_m] = d[CW-1:0];
      ptr_m = (ptr_m + 1) % NC;
      if (ptr_m == 0) loaded_m = 1;
    end
  endtask

  // One clock cycle of stimulus; model advances with the same edge.
  task automatic step(input bit we, input logic [7:0] wa, input logic [31:0] wd,
                      input logic [3:0] ws, input bit re, input logic [7:0] ra, input bit fs);
    bit old_pend, xfer;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_strb = ws;
    rd_en = re; rd_addr = ra; frame_start = fs;
    if (re) begin
      last_exp = exp_read(ra);
      exp_q.push_back(last_exp);
    end
    old_pend = pend_m;
    xfer = fs && old_pend;
    if (xfer) begin
      for (int k = 0; k < NC; k++) ac_m[k] = sh_m[k];
      pend_m = 0; valid_m = 1; loaded_m = 0;
    end
    if (we) model_write(wa, wd, ws, old_pend);
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0; frame_start = 0; wr_strb = '0;
    check("commit_done", 32'(commit_done), 32'(xfer));
    check("coeff_valid", 32'(coeff_valid), 32'(valid_m));
    check_flat("active_bank");
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    step(1, a, d, 4'hF, 0, 8'h00, 0);
  endtask
  task automatic rd(input logic [7:0] a);
    step(0, 8'h00, 32'h0, 4'h0, 1, a, 0);
  endtask
  task automatic idle();
    step(0, 8'h00, 32'h0, 4'h0, 0, 8'h00, 0);
  endtask
  task automatic fs_pulse();
    step(0, 8'h00, 32'h0, 4'h0, 0, 8'h00, 1);
  endtask

  function automatic logic [7:0] pick_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel <= 5) return 8'(4 * $urandom_range(0, NC - 1));
    if (sel == 6) return 8'hF0;
    if (sel == 7) return 8'hF8;
    if (sel == 8) return 8'hF4;
    return 8'(100 + 4 * $urandom_range(0, 34));
  endfunction

  // Monitor: a read sampled at an edge is compared once rd_data has settled.
  initial begin
    forever begin
      @(posedge clk);
      if (rd_en && rst_n) begin
        #2;
        if (exp_q.size() == 0) begin
          check("rd_unexpected", rd_data, 32'hDEAD_BEEF);
        end else begin
          check("rd_data", rd_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  a;
    model_reset();
    last_exp = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_rd_data", rd_data, 32'h0);
    idle();

    // Direct writes, sign-extended readback, no effect on active bank
    wr(8'h00, 32'h0000_0003);
    wr(8'h60, 32'h0000_FFFE);
    rd(8'h00);
    rd(8'h60);
    idle();

    // Commit waits for frame_start
    wr(8'hF0, 32'h1);
    idle(); idle(); idle();
    rd(8'hF4);
    fs_pulse();
    idle();
    rd(8'hF4);
    idle();
    check("rd_hold", rd_data, last_exp);

    // Stream port with wrap
    wr(8'hF0, 32'h2);
    for (int i = 1; i <= NC; i++) wr(8'hF8, 32'(i));
    rd(8'hF4);
    for (int k = 0; k < NC; k += 6) rd(8'(4 * k));
    wr(8'hF8, 32'hFFFF_8064);
    rd(8'h00);
    rd(8'hF4);

    // Byte strobes, including lanes above COEFF_W
    wr(8'h14, 32'h0000_0012);
    step(1, 8'h14, 32'h0000_AB00, 4'b0010, 0, 8'h00, 0);
    step(1, 8'h14, 32'h7700_0000, 4'b1100, 0, 8'h00, 0);
    rd(8'h14);

    // COMMIT coincident with frame_start defers; shadow write in transfer cycle excluded
    step(1, 8'hF0, 32'h1, 4'hF, 0, 8'h00, 1);
    rd(8'hF4);
    step(1, 8'h08, 32'h0000_1234, 4'hF, 0, 8'h00, 1);
    rd(8'h08);
    wr(8'hF0, 32'h8);
    rd(8'h08);
    rd(8'hF0);
    wr(8'hF0, 32'h0);

    // Read and write of the same word in one cycle return the old value
    step(1, 8'h0C, 32'h0000_5555, 4'hF, 1, 8'h0C, 0);
    rd(8'h0C);
    rd(8'hFC);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      a = pick_addr();
      d = $urandom();
      if (a == 8'hF0) d = d & 32'hF;
      step($urandom_range(0, 9) < 6, a, d, 4'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1, pick_addr(), $urandom_range(0, 5) == 0);
    end

    // Asynchronous reset while a commit is pending
    wr(8'hF0, 32'h0);
    wr(8'hF0, 32'h1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_commit_done", 32'(commit_done), 32'h0);
    check("rst_coeff_valid", 32'(coeff_valid), 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    check_flat("rst_active_bank");
    @(posedge clk); #1 rst_n = 1'b1;
    idle();
    rd(8'hF4);
    fs_pulse();
    idle();
    rd(8'h00);
    idle(); idle();
    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
